edge_event_arbiter: RTL and testbench
=====================================

# edge_event_arbiter

Multi-channel rising-edge event collector and round-robin scheduler. Each of `N_CH` level inputs is edge-detected in the same way as the single-channel `edge2` detector. A detected edge is latched as a pending event. Pending events are shared onto one registered event port with a valid/ready handshake, one channel per transfer, with fair round-robin service. The block sits between the per-signal edge detection and the single downstream consumer, which counts or logs events.

## Interface

Parameters:
- `N_CH`, default 4: number of input channels. Must be at least 2.
- `CH_W`, default `$clog2(N_CH)`: width of the channel index.

Ports:
- `clk` input, 1: rising-edge clock.
- `n_rst` input, 1: reset, asynchronous and active-low.
- `in` input, `N_CH`: level inputs, synchronous to `clk`.
- `evt_valid` output, 1: an event is offered on `evt_ch`.
- `evt_ch` output, `CH_W`: index of the channel being offered.
- `evt_ready` input, 1: consumer accepts the offered event.
- `ovf` output, `N_CH`: sticky per-channel overflow flags.
- `ovf_clr` input, 1: synchronous pulse that clears all `ovf` bits.

## Operation

- Reset (`n_rst`=0, asynchronous) clears all state:
  - `prev`, `pending` and `ovf` go to 0.
  - `evt_valid` goes to 0 and `evt_ch` goes to 0.
  - `last` (round-robin pointer) goes to `N_CH-1`.
  - The state machine goes to IDLE.
- Edge detection: `edge[i] = in[i] & ~prev[i]`. `prev` is updated with `in` at every `clk` edge.
  - Because `prev` resets to 0, an input already high at the first post-reset edge counts as a rising edge.
- Pending: `pending[i]` is set at the clock edge that samples `edge[i]`=1.
  - It is cleared when channel i is granted.
  - If a grant-clear and a new edge on the same channel occur at the same edge, the set wins.
- Overflow: `ovf[i]` is set when `edge[i]`=1 while `pending[i]`=1 and `pending[i]` is not being cleared at that edge. The new edge is dropped.
  - An edge on the channel currently being offered is not an overflow, because its pending bit is already clear.
  - `ovf_clr`=1 clears all `ovf` bits. If a set and `ovf_clr` coincide on the same bit, the set wins.
- Grant selection: the first pending channel, searching upward from `last+1` modulo `N_CH`.
  - On a grant, `last` takes the granted index.
- State machine, two states:
  - IDLE: if any `pending` bit is set, grant a channel, load `evt_ch`, set `evt_valid`=1 and go to OFFER. Otherwise stay in IDLE.
  - OFFER: `evt_valid` and `evt_ch` hold stable while `evt_ready`=0.
    - On `evt_valid & evt_ready`, if any `pending` bit is set, grant the next channel in the same cycle and stay in OFFER (back-to-back transfers).
    - Otherwise clear `evt_valid` and go to IDLE.
- Pending bits set at the current edge are not visible to the grant logic until the following edge.

## Timing

- All outputs are registered.
- Latency: an input rising edge sampled at posedge k sets `pending` at k. `evt_valid` rises at posedge k+1, provided the output is idle.
- Throughput: one event per cycle while `evt_ready`=1 and events are pending.
- `evt_ch` changes only at IDLE to OFFER, or on an accepted transfer.
- Assertion of `n_rst` mid-offer drops the offered event and all pending events immediately, with no handshake required.

## Test plan

1. **Reset values:** assert `n_rst`=0 with `in`=4'b0000. Required: `evt_valid`=0, `evt_ch`=0, `ovf`=0.
   - Release reset and hold `in`=0 for 5 cycles. Required: `evt_valid` stays 0.
2. **Single edge:** `evt_ready`=1, raise `in[2]` at posedge k and hold it high for 4 cycles. Required: `evt_valid`=1 with `evt_ch`=2 for exactly one cycle, starting at k+1. No further event appears while `in[2]` stays high.
3. **Simultaneous edges:** all four inputs rise together, `evt_ready`=1. Required: `evt_ch` goes 0, 1, 2, 3 on consecutive cycles with `evt_valid` held high. `evt_valid` drops after channel 3.
4. **Backpressure and overflow:**
   - Hold `evt_ready`=0 and pulse `in[1]`. Required: `evt_valid`=1, `evt_ch`=1, held stable.
   - Pulse `in[3]` twice. Required: `ovf[3]`=1 and `ovf[1]`=0.
   - Raise `evt_ready`. Required: channel 1 is accepted, then channel 3 is offered once.
   - Pulse `ovf_clr`. Required: `ovf`=0.
5. **Fairness:** after a grant of channel 1 (`last`=1), make channels 0 and 2 pending simultaneously. Required: channel 2 is offered before channel 0.
6. **Reset mid-offer:** with `evt_ready`=0, `evt_valid`=1 and channel 3 pending, assert `n_rst` for one half-period. Required: `evt_valid` drops immediately, `pending` and `ovf` clear, and no event follows release while `in` is low.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Multi-channel rising-edge event collector with a round-robin scheduler that
// serialises pending events onto one registered valid/ready event port.
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic [N_CH-1:0] in,
    output logic            evt_valid,
    output logic [CH_W-1:0] evt_ch,
    input  logic            evt_ready,
    output logic [N_CH-1:0] ovf,
    input  logic            ovf_clr
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N_CH-1:0] prev_q;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] ovf_q, ovf_d;
    logic [CH_W-1:0] last_q, last_d;
    logic            evt_valid_q, evt_valid_d;
    logic [CH_W-1:0] evt_ch_q, evt_ch_d;

    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] ovf_set;
    logic [N_CH-1:0] grant_mask;
    logic [CH_W-1:0] grant_ch;
    logic [CH_W-1:0] cand;
    logic            grant_found;
    logic            accept;
    logic            do_grant;

    assign rise = in & ~prev_q;

    // Round-robin search: first pending channel at or after last+1, wrapping.
    // NOTE: every signal driven here gets a default at the top of the block so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant_ch    = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = CH_W'((int'(last_q) + k) % N_CH);
            if (!grant_found && pending_q[cand]) begin
                grant_found = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    assign accept     = (state_q == OFFER) && evt_ready;
    assign do_grant   = grant_found && ((state_q == IDLE) || accept);
    assign grant_mask = do_grant ? (N_CH'(1) << grant_ch) : '0;

    // A new edge wins over a grant-clear on the same channel; an edge that
    // finds its channel still pending (and not being granted) is dropped.
    assign ovf_set   = rise & pending_q & ~grant_mask;
    assign pending_d = rise | (pending_q & ~grant_mask);
    assign ovf_d     = ovf_set | (ovf_q & ~{N_CH{ovf_clr}});
    assign last_d    = do_grant ? grant_ch : last_q;

    always_comb begin
        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_d     = OFFER;
                    evt_valid_d = 1'b1;
                    evt_ch_d    = grant_ch;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    if (grant_found) begin
                        evt_ch_d = grant_ch;
                    end else begin
                        state_d     = IDLE;
                        evt_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                evt_valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            pending_q   <= '0;
            ovf_q       <= '0;
            last_q      <= CH_W'(N_CH - 1);
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= in;
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            last_q      <= last_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: vector tables plus hand-written
// sequences for backpressure, overflow, fairness and reset mid-offer.
module tb_edge_event_arbiter;

    localparam int N_CH = 4;
    localparam int CH_W = 2;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic [N_CH-1:0] in_s = '0;
    logic            evt_valid;
    logic [CH_W-1:0] evt_ch;
    logic            evt_ready = 1'b0;
    logic [N_CH-1:0] ovf;
    logic            ovf_clr = 1'b0;

    always #5 clk = ~clk;

    edge_event_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in        (in_s),
        .evt_valid (evt_valid),
        .evt_ch    (evt_ch),
        .evt_ready (evt_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    typedef struct {
        logic [3:0] din;
        logic       rdy;
        logic       clr;
        logic       exp_v;
        logic [1:0] exp_ch;
        logic [3:0] exp_ovf;
    } vec_t;

    typedef struct {
        logic       v;
        logic [1:0] ch;
        logic [3:0] ovf;
    } exp_t;

    exp_t sb[$];
    vec_t tab_a[$];
    vec_t tab_b[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic [3:0] d, input logic r, input logic c,
                                input logic ev, input logic [1:0] ch, input logic [3:0] o);
        vec_t v;
        v.din = d; v.rdy = r; v.clr = c; v.exp_v = ev; v.exp_ch = ch; v.exp_ovf = o;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive at negedge, queue the expectation, compare 1 time unit after the posedge.
    task automatic step(input string name, input logic [3:0] d, input logic r, input logic c,
                        input logic ev, input logic [1:0] ch, input logic [3:0] o);
        exp_t e;
        @(negedge clk);
        in_s      = d;
        evt_ready = r;
        ovf_clr   = c;
        e.v = ev; e.ch = ch; e.ovf = o;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({name, " valid"}, 32'(evt_valid), 32'(e.v));
        if (e.v) check({name, " ch"}, 32'(evt_ch), 32'(e.ch));
        check({name, " ovf"}, 32'(ovf), 32'(e.ovf));
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        n_rst     = 1'b0;
        in_s      = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        #1;
        check({name, " rst valid"}, 32'(evt_valid), 32'd0);
        check({name, " rst ch"}, 32'(evt_ch), 32'd0);
        check({name, " rst ovf"}, 32'(ovf), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset idle (5 cycles) and single edge on channel 2 held high 4 cycles.
        for (int i = 0; i < 5; i++) tab_a.push_back(mk(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000));
        tab_a.push_back(mk(4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000));
        tab_a.push_back(mk(4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000));
        tab_a.push_back(mk(4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000));
        tab_a.push_back(mk(4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000));
        tab_a.push_back(mk(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000));
        tab_a.push_back(mk(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000));

        // All four rise together just after reset: 0,1,2,3 back to back.
        tab_b.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000));
        tab_b.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000));
        tab_b.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000));
        tab_b.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000));
        tab_b.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b1, 2'd3, 4'b0000));
        tab_b.push_back(mk(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000));
        tab_b.push_back(mk(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000));

        #1;
        check("init valid", 32'(evt_valid), 32'd0);
        check("init ovf", 32'(ovf), 32'd0);
        do_reset("t1");
        for (int i = 0; i < tab_a.size(); i++)
            step($sformatf("t12[%0d]", i), tab_a[i].din, tab_a[i].rdy, tab_a[i].clr,
                 tab_a[i].exp_v, tab_a[i].exp_ch, tab_a[i].exp_ovf);

        do_reset("t3");
        for (int i = 0; i < tab_b.size(); i++)
            step($sformatf("t3[%0d]", i), tab_b[i].din, tab_b[i].rdy, tab_b[i].clr,
                 tab_b[i].exp_v, tab_b[i].exp_ch, tab_b[i].exp_ovf);

        // Backpressure and overflow (last = 3 here).
        step("t4 pulse1",    4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000);
        step("t4 offer1",    4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000);
        step("t4 pulse3a",   4'b1000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000);
        step("t4 hold",      4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000);
        step("t4 pulse3b",   4'b1000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1000);
        step("t4 hold2",     4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1000);
        step("t4 accept1",   4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000);
        step("t4 accept3",   4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1000);
        step("t4 idle",      4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1000);
        step("t4 ovf_clr",   4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000);
        step("t4 after_clr", 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000);

        // Fairness: grant 1, then 0 and 2 together -> 2 before 0.
        step("t5 pulse1",  4'b0010, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000);
        step("t5 grant1",  4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000);
        step("t5 pulse02", 4'b0101, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000);
        step("t5 grant2",  4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000);
        step("t5 grant0",  4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000);
        step("t5 idle",    4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000);

        // Reset mid-offer with channel 3 pending and ovf[3] set (last = 0 here).
        step("t6 pulse1",  4'b0010, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000);
        step("t6 offer1",  4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000);
        step("t6 pulse3a", 4'b1000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000);
        step("t6 hold",    4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000);
        step("t6 pulse3b", 4'b1000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1000);
        step("t6 hold2",   4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1000);
        #1;
        n_rst = 1'b0;
        #1;
        check("t6 mid valid", 32'(evt_valid), 32'd0);
        check("t6 mid ch", 32'(evt_ch), 32'd0);
        check("t6 mid ovf", 32'(ovf), 32'd0);
        #4;
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++)
            step($sformatf("t6 post[%0d]", i), 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
